hex_batch_scheduler: RTL and testbench

- Sequences the batched hex-to-screen transform unit across a rectangular axial region (q_min..q_max × r_min..r_max) in raster order: r outer, q inner.
- Packs up to BATCH coordinates per batch, snapshots camera/zoom/layout config once per frame, and issues each batch with a single-cycle valid.
- Captures the transform results and drains them one hex per cycle onto a valid/ready stream toward the rasterizer.

---
 rtl/hex_batch_scheduler_if.sv | 32 +++
 rtl/hex_batch_scheduler.sv | 135 +++++++++++++
 tb/tb_hex_batch_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_batch_scheduler_if.sv
// hex_batch_scheduler_if: batch bus to the transform unit (xf_*) plus the one-hex-per-cycle stream to the rasterizer (out_*)
interface hex_batch_scheduler_if #(parameter int BATCH = 10);
  logic xf_valid_in;
  logic signed [15:0] xf_q [BATCH];
  logic signed [15:0] xf_r [BATCH];
  logic signed [15:0] xf_s [BATCH];
  logic xf_pointy_top;
  logic signed [31:0] xf_hex_size_q16;
  logic signed [31:0] xf_cam_x_q16;
  logic signed [31:0] xf_cam_y_q16;
  logic signed [31:0] xf_zoom_q16;
  logic xf_valid_out;
  logic signed [31:0] xf_x_q16 [BATCH];
  logic signed [31:0] xf_y_q16 [BATCH];
  logic out_valid;
  logic out_ready;
  logic signed [15:0] out_q;
  logic signed [15:0] out_r;
  logic signed [31:0] out_x_q16;
  logic signed [31:0] out_y_q16;
  logic out_last;
  modport master (
    output xf_valid_in, xf_q, xf_r, xf_s, xf_pointy_top, xf_hex_size_q16, xf_cam_x_q16, xf_cam_y_q16, xf_zoom_q16,
    output out_valid, out_q, out_r, out_x_q16, out_y_q16, out_last,
    input xf_valid_out, xf_x_q16, xf_y_q16, out_ready
  );
  modport slave (
    input xf_valid_in, xf_q, xf_r, xf_s, xf_pointy_top, xf_hex_size_q16, xf_cam_x_q16, xf_cam_y_q16, xf_zoom_q16,
    input out_valid, out_q, out_r, out_x_q16, out_y_q16, out_last,
    output xf_valid_out, xf_x_q16, xf_y_q16, out_ready
  );
endinterface

// File: rtl/hex_batch_scheduler.sv
// hex_batch_scheduler: raster-walks an axial region into BATCH-lane transform batches and drains results (ports: clk/reset, start+bounds+cfg in, busy/done/hex_count out, bus = xf_* batch bus and out_* stream)
module hex_batch_scheduler #(
  parameter int BATCH = 10,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic signed [15:0] q_min,
  input  logic signed [15:0] q_max,
  input  logic signed [15:0] r_min,
  input  logic signed [15:0] r_max,
  input  logic cfg_pointy_top,
  input  logic signed [31:0] cfg_hex_size_q16,
  input  logic signed [31:0] cfg_cam_x_q16,
  input  logic signed [31:0] cfg_cam_y_q16,
  input  logic signed [31:0] cfg_zoom_q16,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] hex_count,
  hex_batch_scheduler_if.master bus
);
  localparam int NW = $clog2(BATCH + 1);
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, DRAIN = 3'd4, FIN = 3'd5;
  logic [2:0] state;
  logic signed [15:0] lo_q, hi_q, hi_r, cur_q, cur_r;
  logic [NW-1:0] n, k;
  logic exhausted, region_end, batch_end;
  logic [16:0] s_wide;
  logic signed [15:0] lane_q [BATCH];
  logic signed [15:0] lane_r [BATCH];
  logic signed [15:0] lane_s [BATCH];
  logic signed [31:0] lane_x [BATCH];
  logic signed [31:0] lane_y [BATCH];
  logic pointy;
  logic signed [31:0] size, cam_x, cam_y, zoom;
  assign region_end = cur_q == hi_q && cur_r == hi_r;
  assign batch_end = region_end || n == NW'(BATCH - 1);
  assign s_wide = -{cur_q[15], cur_q} - {cur_r[15], cur_r};
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign bus.xf_valid_in = state == ISSUE;
  assign bus.xf_q = lane_q;
  assign bus.xf_r = lane_r;
  assign bus.xf_s = lane_s;
  assign bus.xf_pointy_top = pointy;
  assign bus.xf_hex_size_q16 = size;
  assign bus.xf_cam_x_q16 = cam_x;
  assign bus.xf_cam_y_q16 = cam_y;
  assign bus.xf_zoom_q16 = zoom;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_q = lane_q[k];
  assign bus.out_r = lane_r[k];
  assign bus.out_x_q16 = lane_x[k];
  assign bus.out_y_q16 = lane_y[k];
  assign bus.out_last = state == DRAIN && exhausted && k == n - NW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      hi_r <= '0;
      cur_q <= '0;
      cur_r <= '0;
      n <= '0;
      k <= '0;
      exhausted <= 1'b0;
      hex_count <= '0;
      pointy <= 1'b0;
      size <= '0;
      cam_x <= '0;
      cam_y <= '0;
      zoom <= '0;
      for (int i = 0; i < BATCH; i++) begin
        lane_q[i] <= '0;
        lane_r[i] <= '0;
        lane_s[i] <= '0;
        lane_x[i] <= '0;
        lane_y[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          lo_q <= q_min;
          hi_q <= q_max;
          hi_r <= r_max;
          cur_q <= q_min;
          cur_r <= r_min;
          n <= '0;
          k <= '0;
          exhausted <= 1'b0;
          hex_count <= '0;
          pointy <= cfg_pointy_top;
          size <= cfg_hex_size_q16;
          cam_x <= cfg_cam_x_q16;
          cam_y <= cfg_cam_y_q16;
          zoom <= cfg_zoom_q16;
          state <= (q_min > q_max || r_min > r_max) ? FIN : FILL;
        end
        FILL: begin
          // lane n gets the current hex; lanes above it are zeroed so a short final batch leaves them clear
          for (int i = 0; i < BATCH; i++)
            if (NW'(i) >= n) begin
              lane_q[i] <= NW'(i) == n ? cur_q : '0;
              lane_r[i] <= NW'(i) == n ? cur_r : '0;
              lane_s[i] <= NW'(i) == n ? s_wide[15:0] : '0;
            end
          n <= n + NW'(1);
          // at the last hex nothing advances, so bounds at +32767 never overflow
          cur_q <= region_end ? cur_q : cur_q == hi_q ? lo_q : cur_q + 16'sd1;
          cur_r <= !region_end && cur_q == hi_q ? cur_r + 16'sd1 : cur_r;
          exhausted <= region_end;
          state <= batch_end ? ISSUE : FILL;
        end
        ISSUE: state <= WAIT;
        WAIT: if (bus.xf_valid_out) begin
          for (int i = 0; i < BATCH; i++) begin
            lane_x[i] <= NW'(i) < n ? bus.xf_x_q16[i] : '0;
            lane_y[i] <= NW'(i) < n ? bus.xf_y_q16[i] : '0;
          end
          k <= '0;
          state <= DRAIN;
        end
        DRAIN: if (bus.out_ready) begin
          hex_count <= hex_count + CNT_W'(1);
          k <= k == n - NW'(1) ? '0 : k + NW'(1);
          n <= k == n - NW'(1) ? '0 : n;
          state <= k != n - NW'(1) ? DRAIN : exhausted ? FIN : FILL;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_batch_scheduler.sv
// tb_hex_batch_scheduler: randomized frames against a raster-order reference list with a behavioural transform unit
module tb_hex_batch_scheduler;
  localparam int BATCH = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] q_min = '0, q_max = '0, r_min = '0, r_max = '0;
  logic cfg_pointy_top = 1'b0;
  logic signed [31:0] cfg_hex_size_q16 = '0, cfg_cam_x_q16 = '0, cfg_cam_y_q16 = '0, cfg_zoom_q16 = '0;
  logic busy, done;
  logic [31:0] hex_count;
  int n_cmp = 0, n_bad = 0;
  int eq[$], er[$];
  int total = 0, issued = 0, issues = 0, lat_max = 1;
  hex_batch_scheduler_if #(.BATCH(BATCH)) bus();
  hex_batch_scheduler #(.BATCH(BATCH), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .q_min(q_min), .q_max(q_max), .r_min(r_min), .r_max(r_max),
    .cfg_pointy_top(cfg_pointy_top), .cfg_hex_size_q16(cfg_hex_size_q16),
    .cfg_cam_x_q16(cfg_cam_x_q16), .cfg_cam_y_q16(cfg_cam_y_q16), .cfg_zoom_q16(cfg_zoom_q16),
    .busy(busy), .done(done), .hex_count(hex_count), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int fx(int q, int r);
    return q * 65536 + r * 3 + 7;
  endfunction
  function automatic int fy(int q, int r);
    return r * 65536 - q * 5 + 11;
  endfunction
  function automatic logic signed [15:0] s_of(int q, int r);
    int s;
    s = -q - r;
    return 16'(s);
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hex_count"}, hex_count, 0);
    chk({tag, "_xf_valid_in"}, bus.xf_valid_in, 0);
    chk({tag, "_xf_pointy"}, bus.xf_pointy_top, 0);
    chk({tag, "_xf_size"}, bus.xf_hex_size_q16, 0);
    chk({tag, "_xf_cam_x"}, bus.xf_cam_x_q16, 0);
    chk({tag, "_xf_cam_y"}, bus.xf_cam_y_q16, 0);
    chk({tag, "_xf_zoom"}, bus.xf_zoom_q16, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_q"}, bus.out_q, 0);
    chk({tag, "_out_r"}, bus.out_r, 0);
    chk({tag, "_out_x"}, bus.out_x_q16, 0);
    chk({tag, "_out_y"}, bus.out_y_q16, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    for (int i = 0; i < BATCH; i++) begin
      chk({tag, "_lane_q"}, bus.xf_q[i], 0);
      chk({tag, "_lane_r"}, bus.xf_r[i], 0);
      chk({tag, "_lane_s"}, bus.xf_s[i], 0);
    end
  endtask
  // behavioural transform unit: checks each issued batch against the reference list, answers after 1..lat_max cycles
  initial begin
    int pend, nexp;
    int cq [BATCH];
    int cr [BATCH];
    pend = 0;
    nexp = 0;
    bus.xf_valid_out = 1'b0;
    for (int i = 0; i < BATCH; i++) begin
      bus.xf_x_q16[i] = '0;
      bus.xf_y_q16[i] = '0;
    end
    forever begin
      @(negedge clk);
      bus.xf_valid_out = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.xf_valid_out = 1'b1;
          for (int i = 0; i < BATCH; i++) begin
            bus.xf_x_q16[i] = i < nexp ? fx(cq[i], cr[i]) : $urandom;
            bus.xf_y_q16[i] = i < nexp ? fy(cq[i], cr[i]) : $urandom;
          end
        end
      end else if (bus.xf_valid_in) begin
        issues++;
        nexp = total - issued;
        nexp = nexp > BATCH ? BATCH : nexp < 0 ? 0 : nexp;
        for (int i = 0; i < BATCH; i++) begin
          if (i < nexp) begin
            chk("lane_q", bus.xf_q[i], 16'(eq[issued + i]));
            chk("lane_r", bus.xf_r[i], 16'(er[issued + i]));
            chk("lane_s", bus.xf_s[i], s_of(eq[issued + i], er[issued + i]));
          end else begin
            chk("unused_lane_q", bus.xf_q[i], 0);
            chk("unused_lane_r", bus.xf_r[i], 0);
            chk("unused_lane_s", bus.xf_s[i], 0);
          end
          cq[i] = int'(bus.xf_q[i]);
          cr[i] = int'(bus.xf_r[i]);
        end
        issued += nexp;
        pend = $urandom_range(1, lat_max);
      end
    end
  end
  task automatic run_frame(input int qa, input int qb, input int ra, input int rb,
                           input int mode, input bit perturb, input bit abort);
    int rx;
    bit seen_done, prev_v, prev_rdy, prev_l;
    logic signed [15:0] pq, pr;
    logic signed [31:0] px, py, sz, cx, cy, zm;
    logic pt;
    eq.delete();
    er.delete();
    for (int r = ra; r <= rb; r++)
      for (int q = qa; q <= qb; q++) begin
        eq.push_back(q);
        er.push_back(r);
      end
    total = eq.size();
    issued = 0;
    issues = 0;
    rx = 0;
    seen_done = 0;
    prev_v = 0;
    prev_rdy = 0;
    prev_l = 0;
    pq = '0; pr = '0; px = '0; py = '0;
    @(negedge clk);
    q_min = 16'(qa); q_max = 16'(qb); r_min = 16'(ra); r_max = 16'(rb);
    pt = 1'($urandom_range(0, 1)); sz = $urandom; cx = $urandom; cy = $urandom; zm = $urandom;
    cfg_pointy_top = pt; cfg_hex_size_q16 = sz; cfg_cam_x_q16 = cx; cfg_cam_y_q16 = cy; cfg_zoom_q16 = zm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("hex_count_cleared", hex_count, 0);
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      if (prev_v && !prev_rdy) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_q", bus.out_q, pq);
        chk("stall_r", bus.out_r, pr);
        chk("stall_x", bus.out_x_q16, px);
        chk("stall_y", bus.out_y_q16, py);
        chk("stall_last", bus.out_last, prev_l);
      end
      if (bus.out_valid) begin
        chk("hex_count_run", hex_count, rx);
        if (bus.out_ready) begin
          chk("no_extra_out", rx < total, 1);
          if (rx < total) begin
            chk("out_q", bus.out_q, 16'(eq[rx]));
            chk("out_r", bus.out_r, 16'(er[rx]));
            chk("out_x", bus.out_x_q16, fx(eq[rx], er[rx]));
            chk("out_y", bus.out_y_q16, fy(eq[rx], er[rx]));
            chk("out_last", bus.out_last, rx == total - 1);
          end
          rx++;
        end
      end
      prev_v = bus.out_valid;
      prev_rdy = bus.out_ready;
      prev_l = bus.out_last;
      pq = bus.out_q; pr = bus.out_r; px = bus.out_x_q16; py = bus.out_y_q16;
      if (done) begin
        seen_done = 1;
        start = 1'b0;
      end else if (abort && issues == 2 && busy && !bus.xf_valid_in) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("abort");
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          chk("abort_no_valid", bus.out_valid, 0);
          chk("abort_idle", busy, 0);
          chk("abort_no_done", done, 0);
        end
        return;
      end else if (perturb && busy) begin
        start = 1'($urandom_range(0, 1));
        cfg_zoom_q16 = $urandom;
        cfg_cam_x_q16 = $urandom;
        cfg_pointy_top = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("rx_total", rx, total);
    chk("hex_count_final", hex_count, total);
    chk("issue_count", issues, (total + BATCH - 1) / BATCH);
    chk("snap_pointy", bus.xf_pointy_top, pt);
    chk("snap_size", bus.xf_hex_size_q16, sz);
    chk("snap_cam_x", bus.xf_cam_x_q16, cx);
    chk("snap_cam_y", bus.xf_cam_y_q16, cy);
    chk("snap_zoom", bus.xf_zoom_q16, zm);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("hex_count_hold", hex_count, total);
  endtask
  initial begin
    int qa, ra;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    lat_max = 1;
    run_frame(0, 1, 0, 1, 0, 0, 0);
    run_frame(-1, 1, 0, 3, 0, 0, 0);
    run_frame(0, 1, 0, 1, 1, 0, 0);
    run_frame(3, 2, 0, 1, 0, 0, 0);
    run_frame(0, 1, 5, 4, 0, 0, 0);
    run_frame(5, 5, -7, -7, 0, 0, 0);
    lat_max = 3;
    run_frame(-1, 1, 0, 3, 2, 1, 0);
    run_frame(-1, 1, 0, 3, 0, 0, 1);
    run_frame(0, 1, 0, 1, 0, 0, 0);
    run_frame(32765, 32767, 32766, 32767, 2, 0, 0);
    run_frame(-32768, -32766, -32768, -32767, 1, 0, 0);
    for (int t = 0; t < 8; t++) begin
      lat_max = $urandom_range(1, 3);
      qa = $urandom_range(0, 40) - 20;
      ra = $urandom_range(0, 40) - 20;
      run_frame(qa, qa + $urandom_range(0, 6), ra, ra + $urandom_range(0, 5),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
